score_keeper: RTL

Game score accumulator feeding the ASCII score converter. Tracks the game phase, accumulates points from hit events with saturation, applies miss penalties and combo bonuses, and holds the best score across games. Outputs are registered; `score` connects directly to the converter's 8-bit score input, which displays values 0..99.

---
 rtl/score_keeper.sv | 99 +++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Game score accumulator: phase FSM, saturating hit/miss/combo scoring, optional best-score tracking.
// Latency 1 cycle, registered outputs; no backpressure. Best-score logic built only with SCORE_KEEPER_HISCORE_EN.
module score_keeper #(
    parameter int MAX_SCORE    = 99,
    parameter int COMBO_LEN    = 5,
    parameter int COMBO_BONUS  = 5,
    parameter int MISS_PENALTY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic       game_over,
    input  logic       hit,
    input  logic [3:0] hit_points,
    input  logic       miss,
    output logic [7:0] score,
    output logic [7:0] best_score,
    output logic [3:0] combo,
    output logic       playing,
    output logic       new_record
);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t     state, state_nxt;
    logic [7:0] score_nxt;
    logic [3:0] combo_nxt;
    logic [3:0] combo_inc;
    logic       combo_done;
    logic [8:0] sum;
    logic       record_nxt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            score   <= '0;
            combo   <= '0;
            playing <= 1'b0;
        end else begin
            state   <= state_nxt;
            score   <= score_nxt;
            combo   <= combo_nxt;
            playing <= (state_nxt == PLAY);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, OVER: if (game_start) state_nxt = PLAY;
            PLAY: begin
                if (game_start)     state_nxt = PLAY;
                else if (game_over) state_nxt = OVER;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        combo_inc  = combo + 4'd1;
        combo_done = (combo_inc == 4'(COMBO_LEN));
        sum        = {1'b0, score} + {5'b0, hit_points} + (combo_done ? 9'(COMBO_BONUS) : 9'd0);
        score_nxt  = score;
        combo_nxt  = combo;
        record_nxt = 1'b0;
        // game_start clears in every state: it either enters or restarts PLAY
        if (game_start) begin
            score_nxt = '0;
            combo_nxt = '0;
        end else if (state == PLAY) begin
            if (game_over) begin
                record_nxt = (score > best_score);
            end else if (miss) begin
                combo_nxt = '0;
                score_nxt = (score < 8'(MISS_PENALTY)) ? 8'd0 : score - 8'(MISS_PENALTY);
            end else if (hit) begin
                combo_nxt = combo_done ? 4'd0 : combo_inc;
                score_nxt = (sum > 9'(MAX_SCORE)) ? 8'(MAX_SCORE) : sum[7:0];
            end
        end
    end

`ifdef SCORE_KEEPER_HISCORE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            best_score <= '0;
            new_record <= 1'b0;
        end else begin
            new_record <= record_nxt;
            if (record_nxt) best_score <= score;
        end
    end
`else
    assign best_score = '0;
    assign new_record = 1'b0;
`endif

endmodule
